ifetch_queue: RTL and testbench

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/ifetch_queue_pkg.sv | 16 +
 rtl/ifq_fifo.sv | 50 +++++
 rtl/ifetch_queue.sv | 124 ++++++++++++
 tb/tb_ifetch_queue.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_queue_pkg.sv
// Shared pipeline definitions for the instruction fetch front end.
//   WORD_W        : instruction / address word width
//   PC_INC        : sequential fetch increment (one 32-bit word)
//   fetch_state_t : fetch FSM state encoding
package ifetch_queue_pkg;

   localparam int WORD_W = 32;
   localparam logic [WORD_W-1:0] PC_INC = 32'd4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DROP = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/ifq_fifo.sv
// Circular instruction queue storage.
//   clk, reset : clock, synchronous active-high reset
//   push       : write push_data at the tail
//   pop        : retire the head entry
//   flush      : empty the queue next cycle (dominates push/pop)
//   count      : number of occupied entries, 0..DEPTH
//   head_data  : entry at the head (undefined when count == 0)
module ifq_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] push_data,
   output logic [PTR_W:0]   count,
   output logic [WIDTH-1:0] head_data
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // DEPTH is a power of two, so plain pointer increment wraps modulo DEPTH.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush && !reset) mem[wr_ptr] <= push_data;
   end

   assign head_data = mem[rd_ptr];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch unit: single-outstanding-request fetch FSM feeding a
// small instruction queue towards decode.
//   clk, reset        : clock, synchronous active-high reset
//   redirect          : taken branch; flush queue and refetch at redirect_pc
//   redirect_pc       : new fetch address
//   stall             : decode cannot take the head this cycle
//   imem_req/addr     : instruction memory request and its word address
//   imem_ack/rdata    : memory response
//   valid             : queue head presented to decode
//   instruction       : head instruction word (0 when !valid)
//   next_pc           : head address + 4 (0 when !valid)
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no request outstanding; issue when the queue has room
// WAIT    | request outstanding, response will be queued
// DROP    | request outstanding but redirected; response is thrown away
module ifetch_queue
   import ifetch_queue_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              redirect,
   input  logic [WORD_W-1:0] redirect_pc,
   input  logic              stall,
   output logic              imem_req,
   output logic [WORD_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [WORD_W-1:0] imem_rdata,
   output logic              valid,
   output logic [WORD_W-1:0] instruction,
   output logic [WORD_W-1:0] next_pc
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   fetch_state_t      state, state_nxt;
   logic [WORD_W-1:0] fetch_pc, fetch_pc_nxt;
   logic [WORD_W-1:0] req_addr, req_addr_nxt;
   logic [WORD_W-1:0] req_plus4;
   logic              push;
   logic              pop;
   logic [CNT_W-1:0]  count;
   logic [2*WORD_W-1:0] head_data;

   assign req_plus4 = req_addr + PC_INC;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         fetch_pc <= RESET_PC;
         req_addr <= RESET_PC;
      end else begin
         state    <= state_nxt;
         fetch_pc <= fetch_pc_nxt;
         req_addr <= req_addr_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      req_addr_nxt = req_addr;
      push         = 1'b0;
      case (state)
         ST_IDLE: begin
            if (redirect) begin
               fetch_pc_nxt = redirect_pc;
            end else if (count < FULL_CNT) begin
               state_nxt    = ST_WAIT;
               req_addr_nxt = fetch_pc;
            end
         end
         ST_WAIT: begin
            if (imem_ack) begin
               state_nxt = ST_IDLE;
               if (redirect) begin
                  fetch_pc_nxt = redirect_pc;
               end else begin
                  push         = 1'b1;
                  fetch_pc_nxt = req_plus4;
               end
            end else if (redirect) begin
               fetch_pc_nxt = redirect_pc;
               state_nxt    = ST_DROP;
            end
         end
         ST_DROP: begin
            if (redirect) fetch_pc_nxt = redirect_pc;
            if (imem_ack) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign imem_req  = (state == ST_WAIT) || (state == ST_DROP);
   assign imem_addr = req_addr;

   // A redirect wipes the queue, so the head is not consumed that cycle.
   assign pop = valid && !stall && !redirect;

   ifq_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (2*WORD_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .flush     (redirect),
      .push_data ({imem_rdata, req_plus4}),
      .count     (count),
      .head_data (head_data)
   );

   assign valid       = (count != '0);
   assign instruction = valid ? head_data[2*WORD_W-1:WORD_W] : '0;
   assign next_pc     = valid ? head_data[WORD_W-1:0]        : '0;

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        valid;
   logic [31:0] instruction;
   logic [31:0] next_pc;

   int n_vec  = 0;
   int n_miss = 0;

   ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .reset       (reset),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .stall       (stall),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .valid       (valid),
      .instruction (instruction),
      .next_pc     (next_pc)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Inputs are driven and outputs sampled at the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [31:0] dat(input int i);
      return 32'hA5A5_0000 | 32'(i);
   endfunction

   task automatic do_reset();
      reset       = 1'b1;
      redirect    = 1'b0;
      redirect_pc = '0;
      stall       = 1'b0;
      imem_ack    = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      int nreq;
      bit got;

      @(negedge clk);

      // reset values, then three sequential fetches with immediate ack
      do_reset();
      chk("rst_req",   32'(imem_req), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_instr", instruction, 32'd0);
      chk("rst_npc",   next_pc, 32'd0);
      step();
      for (int i = 0; i < 3; i++) begin
         chk("seq_req",  32'(imem_req), 32'd1);
         chk("seq_addr", imem_addr, 32'(4*i));
         imem_ack   = 1'b1;
         imem_rdata = dat(i);
         step();
         imem_ack   = 1'b0;
         imem_rdata = 32'hDEAD_BEEF;
         chk("seq_lat_valid", 32'(valid), 32'd1);
         chk("seq_npc",   next_pc, 32'(4*i + 4));
         chk("seq_instr", instruction, dat(i));
         chk("seq_req_idle", 32'(imem_req), 32'd0);
         step();
      end

      // stall held: queue fills after DEPTH requests, then drains in order
      do_reset();
      stall = 1'b1;
      nreq  = 0;
      for (int c = 0; c < 30; c++) begin
         if (imem_req) begin
            chk("fill_addr", imem_addr, 32'(4*nreq));
            imem_rdata = dat(nreq);
            nreq++;
         end
         imem_ack = imem_req;
         step();
      end
      imem_ack = 1'b0;
      chk("fill_nreq",  32'(nreq), 32'd4);
      chk("fill_req",   32'(imem_req), 32'd0);
      chk("fill_valid", 32'(valid), 32'd1);
      stall = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("drain_valid", 32'(valid), 32'd1);
         chk("drain_npc",   next_pc, 32'(4*k + 4));
         chk("drain_instr", instruction, dat(k));
         step();
      end
      chk("drain_empty", 32'(valid), 32'd0);

      // redirect in WAIT, ack three cycles later is dropped
      do_reset();
      step();
      chk("rdw_req", 32'(imem_req), 32'd1);
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0100;
      step();
      redirect = 1'b0;
      chk("rdw_drop_req",  32'(imem_req), 32'd1);
      chk("rdw_drop_addr", imem_addr, 32'd0);
      chk("rdw_valid0",    32'(valid), 32'd0);
      step();
      chk("rdw_valid1", 32'(valid), 32'd0);
      step();
      imem_ack   = 1'b1;
      imem_rdata = 32'h0BAD_0BAD;
      step();
      imem_ack = 1'b0;
      chk("rdw_idle",   32'(imem_req), 32'd0);
      chk("rdw_valid2", 32'(valid), 32'd0);
      step();
      chk("rdw_new_req",  32'(imem_req), 32'd1);
      chk("rdw_new_addr", imem_addr, 32'h0000_0100);
      chk("rdw_valid3",   32'(valid), 32'd0);
      imem_ack   = 1'b1;
      imem_rdata = 32'h1234_5678;
      step();
      imem_ack = 1'b0;
      chk("rdw_valid4", 32'(valid), 32'd1);
      chk("rdw_npc",    next_pc, 32'h0000_0104);
      chk("rdw_instr",  instruction, 32'h1234_5678);

      // redirect and ack in the same cycle
      do_reset();
      step();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0200;
      imem_ack    = 1'b1;
      imem_rdata  = 32'h0BAD_0001;
      step();
      redirect = 1'b0;
      imem_ack = 1'b0;
      chk("rda_valid", 32'(valid), 32'd0);
      chk("rda_req",   32'(imem_req), 32'd0);
      step();
      chk("rda_valid1", 32'(valid), 32'd0);
      chk("rda_addr",   imem_addr, 32'h0000_0200);
      imem_ack   = 1'b1;
      imem_rdata = 32'h2222_2222;
      step();
      imem_ack = 1'b0;
      chk("rda_npc", next_pc, 32'h0000_0204);

      // ack of the last free slot coincident with a pop keeps order
      do_reset();
      stall = 1'b1;
      nreq  = 0;
      got   = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
         if (imem_req && nreq == 3) begin
            got = 1'b1;
         end else begin
            if (imem_req) begin
               imem_rdata = dat(nreq);
               nreq++;
            end
            imem_ack = imem_req;
            step();
         end
      end
      imem_ack = 1'b0;
      chk("pp_got4th", 32'(got), 32'd1);
      chk("pp_addr",   imem_addr, 32'd12);
      chk("pp_head",   next_pc, 32'd4);
      stall      = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = dat(3);
      step();
      imem_ack = 1'b0;
      for (int k = 1; k < 4; k++) begin
         chk("pp_valid", 32'(valid), 32'd1);
         chk("pp_npc",   next_pc, 32'(4*k + 4));
         chk("pp_instr", instruction, dat(k));
         step();
      end
      chk("pp_empty", 32'(valid), 32'd0);

      // reset while in DROP with an ack on the reset edge
      do_reset();
      step();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0300;
      step();
      redirect   = 1'b0;
      reset      = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = 32'h0BAD_0002;
      step();
      reset    = 1'b0;
      imem_ack = 1'b0;
      chk("rsd_req",   32'(imem_req), 32'd0);
      chk("rsd_valid", 32'(valid), 32'd0);
      chk("rsd_instr", instruction, 32'd0);
      chk("rsd_npc",   next_pc, 32'd0);
      step();
      chk("rsd_req1",  32'(imem_req), 32'd1);
      chk("rsd_addr",  imem_addr, 32'd0);
      chk("rsd_valid1", 32'(valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
